hash_result_serializer: RTL
===========================

// Module: hash_result_serializer
// PURPOSE
//  Sits directly downstream of the per-PE hash row merge stage. Takes one merged bundle (best
//  candidate per hash PE) and emits it as a stream of single-position match candidates, one per
//  cycle, in ascending PE order, for the match-extension engine. Computes the match offset,
//  drops unusable candidates (short or out of window), and never drops delimiter positions.
// PARAMETERS
//  NUM_PE       `NUM_HASH_PE (16)          PE lanes per bundle
//  ADDR_W       `ADDR_WIDTH (32)           position / history address width
//  LEN_W        `META_MATCH_LEN_WIDTH (3)  meta match length width
//  MIN_LEN      3                          minimum meta_match_len for a usable match
//  WINDOW_SIZE  65536                      maximum legal offset, inclusive
// PORTS
//  clk                   in   1              clock
//  rst_n                 in   1              asynchronous active-low reset
//  input_valid           in   1              bundle valid
//  input_mask            in   NUM_PE         lane carries a real position
//  input_addr            in   NUM_PE*ADDR_W  head position per lane
//  input_history_valid   in   NUM_PE         lane has a candidate
//  input_history_addr    in   NUM_PE*ADDR_W  candidate position per lane
//  input_meta_match_len  in   NUM_PE*LEN_W   candidate meta length per lane
//  input_meta_match_can_ext in NUM_PE        candidate may extend past meta length
//  input_delim           in   NUM_PE         lane ends a block
//  input_ready           out  1              bundle accepted when valid&ready
//  output_valid          out  1              candidate valid
//  output_pe_idx         out  $clog2(NUM_PE) lane index of this candidate
//  output_addr           out  ADDR_W         head position
//  output_match_valid    out  1              usable match
//  output_offset         out  ADDR_W         addr - history_addr; 0 when !match_valid
//  output_match_len      out  LEN_W          meta length; 0 when !match_valid
//  output_can_ext        out  1              can_ext; 0 when !match_valid
//  output_delim          out  1              lane delimiter flag
//  output_last           out  1              final candidate of the bundle
//  output_ready          in   1              consumer ready
// BEHAVIOUR
//  - State: one bundle buffer, plus pending[NUM_PE]. No other FSM: pending==0 is IDLE, else BUSY.
//  - Reset: pending=0, buffer=0. All outputs are 0, except input_ready=1.
//    Reset mid-bundle discards the remaining lanes.
//  - Lane selection: pending loads (input_mask | input_delim) on accept. Delim lanes are
//    emitted even when their mask bit is 0.
//  - Current lane idx = lowest set bit of pending. Outputs are combinational from the buffer at idx.
//  - output_valid = (pending != 0). output_last = pending has exactly one bit set.
//  - On output fire (valid & ready), clear pending[idx]. Outputs hold stable while valid & !ready.
//  - input_ready = (pending==0) | (output_last & output_ready). This allows a back-to-back bundle
//    with no bubble.
//  - Accept overwrites the buffer and pending in the same edge as the last output fire.
//  - Latency: accept at edge t -> first candidate valid after t. Bundle with k lanes = k cycles.
//  - All-zero (mask|delim) bundle: accepted in one cycle, emits nothing, input_ready stays 1.
//  - offset = addr - history_addr, modulo 2^ADDR_W (unsigned wrap).
//  - output_match_valid = history_valid & mask[idx] & (len >= MIN_LEN) & (offset != 0)
//    & (offset <= WINDOW_SIZE).
//  - history_addr > addr wraps to a huge offset and fails the window check.
// TESTING
//  1 Reset: assert rst_n=0 mid-bundle -> output_valid=0, input_ready=1. The next bundle streams
//    from its lowest lane.
//  2 mask=16'h0005, hv=all, addr[0]=100, haddr[0]=40, len=4 -> two candidates:
//    - idx0: offset=60, match_valid=1, last=0.
//    - idx2: last=1.
//  3 output_ready low 3 cycles on idx2 -> fields stable. Next bundle accepted on the same edge
//    idx2 fires; no bubble.
//  4 mask=0, delim=16'h8000 -> one candidate: idx15, delim=1, match_valid=0, last=1.
//    Also: mask=0, delim=0 x4 -> all accepted in 4 cycles, no output.
//  5 Window/length filters:
//    - len=2 -> match_valid=0.
//    - offset=65536 -> match_valid=1.
//    - offset=65537 -> match_valid=0.
//    - haddr=addr+1 -> match_valid=0; offset forced 0.
//  6 Random bundles + random output_ready vs scoreboard: per-lane order, offset and last flags
//    exact, no loss or duplication.

Source files
------------

// File: rtl/hash_result_serializer.sv
// ============================================================================
// Module  : hash_result_serializer
// Brief   : Streams one merged hash bundle as per-lane match candidates.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hash_result_serializer #(
  parameter int NUM_PE      = 16,
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 3,
  parameter int MIN_LEN     = 3,
  parameter int WINDOW_SIZE = 65536
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          input_valid,
  input  logic [NUM_PE-1:0]             input_mask,
  input  logic [NUM_PE*ADDR_W-1:0]      input_addr,
  input  logic [NUM_PE-1:0]             input_history_valid,
  input  logic [NUM_PE*ADDR_W-1:0]      input_history_addr,
  input  logic [NUM_PE*LEN_W-1:0]       input_meta_match_len,
  input  logic [NUM_PE-1:0]             input_meta_match_can_ext,
  input  logic [NUM_PE-1:0]             input_delim,
  output logic                          input_ready,
  output logic                          output_valid,
  output logic [$clog2(NUM_PE)-1:0]     output_pe_idx,
  output logic [ADDR_W-1:0]             output_addr,
  output logic                          output_match_valid,
  output logic [ADDR_W-1:0]             output_offset,
  output logic [LEN_W-1:0]              output_match_len,
  output logic                          output_can_ext,
  output logic                          output_delim,
  output logic                          output_last,
  input  logic                          output_ready
);

  localparam int                c_idx_w   = $clog2(NUM_PE);
  localparam logic [NUM_PE-1:0] c_one     = NUM_PE'(1);
  localparam logic [ADDR_W-1:0] c_window  = ADDR_W'(WINDOW_SIZE);
  localparam logic [LEN_W-1:0]  c_min_len = LEN_W'(MIN_LEN);

  logic [NUM_PE-1:0]        pending_q, pending_d;
  logic [NUM_PE-1:0]        mask_q, mask_d;
  logic [NUM_PE-1:0]        hist_valid_q, hist_valid_d;
  logic [NUM_PE-1:0]        can_ext_q, can_ext_d;
  logic [NUM_PE-1:0]        delim_q, delim_d;
  logic [NUM_PE*ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_PE*ADDR_W-1:0] hist_addr_q, hist_addr_d;
  logic [NUM_PE*LEN_W-1:0]  len_q, len_d;

  logic                     w_accept;
  logic                     w_fire;
  logic                     w_valid;
  logic                     w_last;
  logic [NUM_PE-1:0]        w_onehot;
  logic [c_idx_w-1:0]       w_idx;
  logic [ADDR_W-1:0]        w_addr;
  logic [ADDR_W-1:0]        w_hist_addr;
  logic [ADDR_W-1:0]        w_offset;
  logic [LEN_W-1:0]         w_len;
  logic                     w_match;

  // Isolate the lowest pending lane with the two's-complement trick.
  always_comb begin
    w_onehot = pending_q & (~pending_q + c_one);
    w_idx    = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (w_onehot[i]) w_idx = w_idx | c_idx_w'(i);
    end
  end

  always_comb begin
    w_valid     = (pending_q != '0);
    w_last      = w_valid && ((pending_q & (pending_q - c_one)) == '0);
    w_addr      = addr_q[w_idx*ADDR_W +: ADDR_W];
    w_hist_addr = hist_addr_q[w_idx*ADDR_W +: ADDR_W];
    w_len       = len_q[w_idx*LEN_W +: LEN_W];
    // Unsigned wrap: a history position ahead of the head lands far outside the window.
    w_offset    = w_addr - w_hist_addr;
    w_match     = w_valid && hist_valid_q[w_idx] && mask_q[w_idx] && (w_len >= c_min_len)
                  && (w_offset != '0) && (w_offset <= c_window);
  end

  always_comb begin
    output_valid       = w_valid;
    output_pe_idx      = w_idx;
    output_addr        = w_valid ? w_addr : '0;
    output_match_valid = w_match;
    output_offset      = w_match ? w_offset : '0;
    output_match_len   = w_match ? w_len : '0;
    output_can_ext     = w_match && can_ext_q[w_idx];
    output_delim       = w_valid && delim_q[w_idx];
    output_last        = w_last;
    input_ready        = !w_valid || (w_last && output_ready);
  end

  // A new bundle overwrites the buffer on the same edge the previous last lane fires.
  always_comb begin
    w_accept     = input_valid && input_ready;
    w_fire       = w_valid && output_ready;
    pending_d    = w_fire ? (pending_q & ~w_onehot) : pending_q;
    mask_d       = mask_q;
    hist_valid_d = hist_valid_q;
    can_ext_d    = can_ext_q;
    delim_d      = delim_q;
    addr_d       = addr_q;
    hist_addr_d  = hist_addr_q;
    len_d        = len_q;
    if (w_accept) begin
      pending_d    = input_mask | input_delim;
      mask_d       = input_mask;
      hist_valid_d = input_history_valid;
      can_ext_d    = input_meta_match_can_ext;
      delim_d      = input_delim;
      addr_d       = input_addr;
      hist_addr_d  = input_history_addr;
      len_d        = input_meta_match_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      mask_q       <= '0;
      hist_valid_q <= '0;
      can_ext_q    <= '0;
      delim_q      <= '0;
      addr_q       <= '0;
      hist_addr_q  <= '0;
      len_q        <= '0;
    end else begin
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      hist_valid_q <= hist_valid_d;
      can_ext_q    <= can_ext_d;
      delim_q      <= delim_d;
      addr_q       <= addr_d;
      hist_addr_q  <= hist_addr_d;
      len_q        <= len_d;
    end
  end

endmodule

`default_nettype wire
